perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
Synthesizable, parametrised event-statistics unit that moves the bench-side cycle, instruction and cache hit/request tallies into RTL. It sits beside the cpu core and takes 1-bit event strobes such as I_miss, D_miss, retire and halt. It keeps one free-running cycle counter plus NUM_EVENTS event counters, and freezes all of them when the core halts. A registered read port lets a debug or bench agent fetch any counter, with sticky overflow flags and a selectable saturate/wrap mode.

Parameters:
NUM_EVENTS, 6, number of event counters (counter indices 1..NUM_EVENTS; index 0 is the cycle counter); legal range 1..15
CNT_WIDTH, 32, width of every counter in bits; legal range 4..64
SATURATE, 1, 1 = counters stick at all-ones on overflow; 0 = counters wrap to 0
Derived: SEL_W = clog2(NUM_EVENTS+1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; IDLE -> RUN
halt  input  1  core halt indication; level or pulse
clear  input  1  synchronous clear of all counters and flags
events  input  NUM_EVENTS  event strobes; bit i-1 increments counter i
rd_req  input  1  read request
rd_sel  input  SEL_W  counter index to read
rd_valid  output  1  read data valid; one-cycle pulse
rd_data  output  CNT_WIDTH  counter value
rd_err  output  1  qualifies rd_valid; asserted when rd_sel > NUM_EVENTS
ovf  output  NUM_EVENTS+1  sticky overflow flag per counter (bit 0 = cycle)
state  output  2  00 IDLE, 01 RUN, 10 HALTED

Behaviour:
- Reset (async, rst=1): state=IDLE; all counters=0; ovf=0; rd_valid=0; rd_data=0; rd_err=0. Deassertion takes effect at the next clk edge.
- State machine, priority clear > start > halt within one cycle:
  - IDLE: start -> RUN. halt is ignored. Counters hold.
  - RUN: counter 0 increments every cycle. Counter i increments when events[i-1]=1. halt=1 -> HALTED; the events of the halt cycle are counted, so the halt cycle itself is included in the totals. start in RUN has no effect.
  - HALTED: all counters and ovf are frozen. start is ignored. clear -> IDLE.
  - clear in any state -> IDLE; all counters=0; ovf=0. This overrides a same-cycle increment, so the result is 0, not 1.
  - start and halt in the same IDLE cycle -> RUN. That cycle is not counted. halt must be re-evaluated on the next cycle.
- Increment arithmetic: +1 modulo 2^CNT_WIDTH.
  - SATURATE=1: a counter at all-ones stays at all-ones when incremented, and its ovf bit sets.
  - SATURATE=0: all-ones goes to 0, and its ovf bit sets.
  - An ovf bit stays set until clear or rst.
- Read port:
  - rd_req sampled at edge t gives rd_valid=1 with rd_data and rd_err registered at edge t+1 (latency 1).
  - rd_data is the counter value before edge t's update (pre-increment).
  - rd_req is accepted every cycle (back-to-back, throughput 1) in any state, including during clear.
  - rd_sel > NUM_EVENTS -> rd_data=0, rd_err=1, rd_valid=1.
  - Without rd_req, rd_valid=0 and rd_data/rd_err hold their last value.
- No combinational path from any input to any output.

Test Plan:
- Reset/idle: assert rst, release, wait 5 cycles without start -> state=00; reads of indices 0..6 all return 0 with rd_err=0.
- Basic run (defaults): start at cycle 0; events[0]=1 for 3 cycles, events[1]=1 for 1 cycle; halt on cycle 9 -> state=10; counter0=10, counter1=3, counter2=1; values unchanged 20 cycles later.
- Saturation (CNT_WIDTH=4, SATURATE=1): run 20 cycles -> counter0=15, ovf[0]=1. Wrap (SATURATE=0) same stimulus -> counter0=4, ovf[0]=1.
- Clear priority: with counter1=7, assert clear together with events[0]=1 and start -> counter1=0, ovf=0, state=00.
- Read timing: with events[0]=1 every cycle in RUN, issue rd_req rd_sel=1 at edge t where counter1=5 -> at t+1, rd_valid=1 and rd_data=5 while counter1=6.
- Bad select: rd_sel=7 (NUM_EVENTS=6) -> next cycle rd_valid=1, rd_err=1, rd_data=0. Async rst asserted mid-RUN -> outputs return to reset values immediately.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: free-running cycle counter plus per-event counters with
// a small run/halt controller, sticky overflow flags and a registered read port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset or clear; counters hold, waiting for start
//   RUN     | cycle counter and event counters advance
//   HALTED  | core halted; counters and overflow flags frozen until clear
module perf_counter_bank #(
  parameter int NUM_EVENTS = 6,
  parameter int CNT_WIDTH  = 32,
  parameter bit SATURATE   = 1'b1,
  localparam int SEL_W     = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  clear,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  rd_req,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_err,
  output logic [NUM_EVENTS:0]   ovf,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_OVF = SATURATE ? CNT_MAX : '0;
  localparam logic [SEL_W-1:0]     MAX_SEL = SEL_W'(NUM_EVENTS);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0]   cnt_d [NUM_EVENTS+1];
  logic [NUM_EVENTS:0]    ovf_q, ovf_d;
  logic [NUM_EVENTS:0]    inc;
  logic                   rd_valid_q, rd_valid_d;
  logic [CNT_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                   rd_err_q, rd_err_d;

  // Controller next state and counter update; clear dominates everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    inc     = '0;
    if (clear) begin
      state_d = ST_IDLE;
      for (int i = 0; i <= NUM_EVENTS; i++) cnt_d[i] = '0;
      ovf_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // start with a same-cycle halt still enters RUN; halt is seen next cycle
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          // the halt cycle itself is counted
          inc = {events, 1'b1};
          if (halt) state_d = ST_HALTED;
        end
        ST_HALTED: ;
        default: state_d = ST_IDLE;
      endcase
      for (int i = 0; i <= NUM_EVENTS; i++) begin
        if (inc[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            cnt_d[i] = CNT_OVF;
            ovf_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      end
    end
  end

  // Read port: returns the pre-update value; data/err hold when idle.
  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    if (rd_req) begin
      rd_data_d = '0;
      rd_err_d  = (rd_sel > MAX_SEL);
      for (int i = 0; i <= NUM_EVENTS; i++) begin
        if (rd_sel == SEL_W'(i)) rd_data_d = cnt_q[i];
      end
    end
  end

  // State, counters and read registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      for (int i = 0; i <= NUM_EVENTS; i++) cnt_q[i] <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i <= NUM_EVENTS; i++) cnt_q[i] <= cnt_d[i];
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign ovf      = ovf_q;
  assign state    = state_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: default instance plus two 4-bit
// instances (saturate / wrap) sharing the same stimulus.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst, start, halt, clear, rd_req;
  logic [5:0]  events;
  logic [2:0]  rd_sel;

  logic        rd_valid, rd_err;
  logic [31:0] rd_data;
  logic [6:0]  ovf;
  logic [1:0]  state;

  logic        s_rd_valid, s_rd_err, w_rd_valid, w_rd_err;
  logic [3:0]  s_rd_data, w_rd_data;
  logic [6:0]  s_ovf, w_ovf;
  logic [1:0]  s_state, w_state;

  int n_vec  = 0;
  int n_miss = 0;

  perf_counter_bank dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
    .events(events), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .ovf(ovf), .state(state)
  );

  perf_counter_bank #(.NUM_EVENTS(6), .CNT_WIDTH(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
    .events(events), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_err(s_rd_err),
    .ovf(s_ovf), .state(s_state)
  );

  perf_counter_bank #(.NUM_EVENTS(6), .CNT_WIDTH(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
    .events(events), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(w_rd_valid), .rd_data(w_rd_data), .rd_err(w_rd_err),
    .ovf(w_ovf), .state(w_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle read of the default instance, checked one edge later
  task automatic rd_chk(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    rd_req = 1'b0;
    chk({tag, ".valid"}, 64'(rd_valid), 64'd1);
    chk({tag, ".err"},   64'(rd_err),   64'd0);
    chk({tag, ".data"},  64'(rd_data),  64'(exp));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; clear = 1'b0;
    events = '0; rd_req = 1'b0; rd_sel = '0;
    repeat (2) tick();
    chk("rst.state", 64'(state), 64'd0);
    chk("rst.valid", 64'(rd_valid), 64'd0);
    rst = 1'b0;
    repeat (5) tick();
    chk("idle.state", 64'(state), 64'd0);
    for (int s = 0; s <= 6; s++) rd_chk($sformatf("idle.rd%0d", s), 3'(s), 32'd0);

    // halt ignored in IDLE
    halt = 1'b1; tick(); halt = 1'b0;
    chk("idle.halt_ignored", 64'(state), 64'd0);

    // basic run: 10 counted cycles, halt on the 10th
    start = 1'b1; tick(); start = 1'b0;
    chk("run.state", 64'(state), 64'd1);
    for (int i = 0; i < 10; i++) begin
      events[0] = (i < 3);
      events[1] = (i == 5);
      halt      = (i == 9);
      tick();
    end
    events = '0; halt = 1'b0;
    chk("run.halted", 64'(state), 64'd2);
    rd_chk("run.c0", 3'd0, 32'd10);
    rd_chk("run.c1", 3'd1, 32'd3);
    rd_chk("run.c2", 3'd2, 32'd1);
    rd_chk("run.c3", 3'd3, 32'd0);
    events = 6'h3F;
    repeat (20) tick();
    events = '0;
    rd_chk("frz.c0", 3'd0, 32'd10);
    rd_chk("frz.c1", 3'd1, 32'd3);
    rd_chk("frz.c2", 3'd2, 32'd1);
    tick();
    chk("hold.valid", 64'(rd_valid), 64'd0);
    chk("hold.data",  64'(rd_data),  64'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("halt.start_ignored", 64'(state), 64'd2);
    chk("run.ovf", 64'(ovf), 64'd0);

    // clear priority over start and a same-cycle increment
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr.idle", 64'(state), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    events[0] = 1'b1;
    repeat (7) tick();
    clear = 1'b1; start = 1'b1; rd_req = 1'b1; rd_sel = 3'd1;
    tick();
    clear = 1'b0; start = 1'b0; rd_req = 1'b0; events = '0;
    chk("clr.rd_pre", 64'(rd_data), 64'd7);
    chk("clr.state",  64'(state),   64'd0);
    chk("clr.ovf",    64'(ovf),     64'd0);
    rd_chk("clr.c1", 3'd1, 32'd0);
    rd_chk("clr.c0", 3'd0, 32'd0);

    // start and halt together in IDLE: enters RUN, halt acts next cycle
    start = 1'b1; halt = 1'b1; tick(); start = 1'b0;
    chk("sh.run", 64'(state), 64'd1);
    tick(); halt = 1'b0;
    chk("sh.halted", 64'(state), 64'd2);
    rd_chk("sh.c0", 3'd0, 32'd1);

    // read timing and back-to-back throughput
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    events[0] = 1'b1;
    repeat (5) tick();
    rd_req = 1'b1; rd_sel = 3'd1;
    tick();
    chk("rt.valid", 64'(rd_valid), 64'd1);
    chk("rt.c1_5",  64'(rd_data),  64'd5);
    tick();
    rd_req = 1'b0;
    chk("rt.c1_6",  64'(rd_data),  64'd6);

    // bad select
    rd_req = 1'b1; rd_sel = 3'd7; tick(); rd_req = 1'b0;
    chk("bad.valid", 64'(rd_valid), 64'd1);
    chk("bad.err",   64'(rd_err),   64'd1);
    chk("bad.data",  64'(rd_data),  64'd0);

    // async reset mid-RUN: counter0 = 8 before this read's edge
    rd_chk("ar.c0", 3'd0, 32'd8);
    rst = 1'b1;
    #1;
    chk("ar.state", 64'(state),    64'd0);
    chk("ar.valid", 64'(rd_valid), 64'd0);
    chk("ar.data",  64'(rd_data),  64'd0);
    chk("ar.err",   64'(rd_err),   64'd0);
    events = '0;
    tick();
    rst = 1'b0;
    tick();

    // saturate vs wrap: 20 counted cycles
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      halt = (i == 19);
      tick();
    end
    halt = 1'b0;
    rd_req = 1'b1; rd_sel = 3'd0; tick(); rd_req = 1'b0;
    chk("sat.main_c0", 64'(rd_data),   64'd20);
    chk("sat.c0",      64'(s_rd_data), 64'd15);
    chk("wrap.c0",     64'(w_rd_data), 64'd4);
    chk("sat.ovf",     64'(s_ovf),     64'h01);
    chk("wrap.ovf",    64'(w_ovf),     64'h01);
    chk("sat.main_ovf", 64'(ovf),      64'h00);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("sat.ovf_clr",  64'(s_ovf), 64'h00);
    chk("wrap.ovf_clr", 64'(w_ovf), 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
